// File: rtl/wb_commit_if.sv
// wb_commit_if: mem-stage to writeback-stage entry handshake.
// The mem stage drives an entry; the commit queue answers with ws_allowin.
interface wb_commit_if #(
    parameter int TLBNUM = 16
);
    localparam int IW = (TLBNUM > 1) ? $clog2(TLBNUM) : 1;

    logic          ms_to_ws_valid;
    logic          ws_allowin;
    logic [31:0]   in_pc;
    logic [31:0]   in_result;
    logic          in_gr_we;
    logic [4:0]    in_dest;
    logic [15:0]   in_ex_cause;
    logic          in_ertn;
    logic          in_refetch;
    logic [4:0]    in_tlbop;
    logic [IW-1:0] tlb_index;

    modport master (
        output ms_to_ws_valid, in_pc, in_result, in_gr_we, in_dest,
        output in_ex_cause, in_ertn, in_refetch, in_tlbop, tlb_index,
        input  ws_allowin
    );

    modport slave (
        input  ms_to_ws_valid, in_pc, in_result, in_gr_we, in_dest,
        input  in_ex_cause, in_ertn, in_refetch, in_tlbop, tlb_index,
        output ws_allowin
    );
endinterface

// File: rtl/wb_commit.sv
// wb_commit: in-order commit queue; retires the head into RF/CSR/TLB and flushes.
// Define WB_COMMIT_PERF_CNT_EN to add retire/flush performance counters.
module wb_commit #(
    parameter int DEPTH  = 2,
    parameter int TLBNUM = 16
) (
    input  logic        clk,
    input  logic        reset,
    wb_commit_if.slave  up,
    input  logic        retire_en,
    input  logic [31:0] era_entry,
    input  logic [31:0] ex_entry,
    input  logic [31:0] tlbr_entry,
    output logic        rf_we,
    output logic [4:0]  rf_waddr,
    output logic [31:0] rf_wdata,
    output logic [4:0]  fwd_dest,
    output logic [31:0] fwd_value,
    output logic        flush,
    output logic [31:0] flush_target,
    output logic        ex_valid,
    output logic [5:0]  ex_ecode,
    output logic [8:0]  ex_esubcode,
    output logic [31:0] ex_pc,
    output logic        tlb_we,
    output logic        tlb_re
`ifdef WB_COMMIT_PERF_CNT_EN
    ,
    output logic [31:0] perf_retire_cnt,
    output logic [31:0] perf_flush_cnt
`endif
);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam int IW = (TLBNUM > 1) ? $clog2(TLBNUM) : 1;
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [DEPTH-1:0] valid;
    logic [31:0]      pc_q     [DEPTH];
    logic [31:0]      result_q [DEPTH];
    logic [4:0]       dest_q   [DEPTH];
    logic [15:0]      cause_q  [DEPTH];
    logic [DEPTH-1:0] gr_we_q;
    logic [DEPTH-1:0] ertn_q;
    logic [DEPTH-1:0] refetch_q;
    logic [DEPTH-1:0] tlbw_q;
    logic [DEPTH-1:0] tlbr_q;

    logic [PW-1:0] head;
    logic [PW-1:0] tail;
    logic [CW-1:0] count;

    logic          retire;
    logic          hx;
    logic          allow;
    logic          enq;
    logic [15:0]   cause;
    logic [5:0]    ecode;
    logic [8:0]    esub;

    // tlbsrch/tlbinv and the index are consumed elsewhere in the pipeline.
    logic [IW-1:0] idx_unused;
    logic          unused_bits;
    assign idx_unused  = up.tlb_index;
    assign unused_bits = ^{up.in_tlbop[4], up.in_tlbop[0], idx_unused};

    assign retire = (count != '0) && retire_en;
    assign cause  = cause_q[head];
    assign hx     = |cause;
    assign flush  = retire && (hx || ertn_q[head] || refetch_q[head]);
    assign allow  = !flush && ((count != FULL) || retire);
    assign enq    = up.ms_to_ws_valid && allow;

    assign up.ws_allowin = allow;

    always_comb begin
        ecode = 6'h00;
        esub  = 9'h000;
        if      (cause[2])  ecode = 6'h08;
        else if (cause[1])  ecode = 6'h0B;
        else if (cause[3])  ecode = 6'h09;
        else if (cause[4])  ecode = 6'h0C;
        else if (cause[5])  ecode = 6'h0D;
        else if (cause[8])  ecode = 6'h02;
        else if (cause[7])  ecode = 6'h07;
        else if (cause[6])  ecode = 6'h04;
        else if (cause[9])  ecode = 6'h01;
        else if (cause[10]) ecode = 6'h03;
        else if (cause[13]) begin
            ecode = 6'h08;
            esub  = 9'h001;
        end
        else if (cause[11]) ecode = 6'h3F;
    end

    always_comb begin
        rf_we        = 1'b0;
        rf_waddr     = '0;
        rf_wdata     = '0;
        ex_valid     = 1'b0;
        ex_ecode     = '0;
        ex_esubcode  = '0;
        ex_pc        = '0;
        tlb_we       = 1'b0;
        tlb_re       = 1'b0;
        flush_target = '0;
        if (retire) begin
            if (hx) begin
                ex_valid    = 1'b1;
                ex_ecode    = ecode;
                ex_esubcode = esub;
                ex_pc       = pc_q[head];
            end else begin
                rf_we    = gr_we_q[head];
                rf_waddr = dest_q[head];
                rf_wdata = result_q[head];
                tlb_we   = tlbw_q[head];
                tlb_re   = tlbr_q[head];
            end
            if (ertn_q[head])         flush_target = era_entry;
            else if (hx && ecode == 6'h3F) flush_target = tlbr_entry;
            else if (hx)              flush_target = ex_entry;
            else                      flush_target = pc_q[head] + 32'd4;
        end
    end

    // Walk oldest to youngest so the youngest writer overrides.
    always_comb begin
        logic [PW-1:0] idx;
        idx       = '0;
        fwd_dest  = '0;
        fwd_value = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = PW'((int'(head) + i) % DEPTH);
            if (valid[idx] && gr_we_q[idx]) begin
                fwd_dest  = dest_q[idx];
                fwd_value = result_q[idx];
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            valid <= '0;
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (retire) begin
                valid[head] <= 1'b0;
                head        <= (head == LAST) ? '0 : head + 1'b1;
            end
            if (enq) begin
                valid[tail] <= 1'b1;
                tail        <= (tail == LAST) ? '0 : tail + 1'b1;
            end
            if (enq && !retire)      count <= count + 1'b1;
            else if (!enq && retire) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            pc_q[tail]      <= up.in_pc;
            result_q[tail]  <= up.in_result;
            dest_q[tail]    <= up.in_dest;
            cause_q[tail]   <= up.in_ex_cause;
            gr_we_q[tail]   <= up.in_gr_we;
            ertn_q[tail]    <= up.in_ertn;
            refetch_q[tail] <= up.in_refetch;
            tlbw_q[tail]    <= up.in_tlbop[2] | up.in_tlbop[1];
            tlbr_q[tail]    <= up.in_tlbop[3];
        end
    end

`ifdef WB_COMMIT_PERF_CNT_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_retire_cnt <= '0;
            perf_flush_cnt  <= '0;
        end else begin
            if (retire) perf_retire_cnt <= perf_retire_cnt + 32'd1;
            if (flush)  perf_flush_cnt  <= perf_flush_cnt + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_wb_commit.sv
// tb_wb_commit: queue-model scoreboard plus directed commit scenarios.
// Perf counter checks follow WB_COMMIT_PERF_CNT_EN.
module tb_wb_commit;
    localparam int DEPTH = 2;
    localparam int PB[12] = '{2, 1, 3, 4, 5, 8, 7, 6, 9, 10, 13, 11};
    localparam int PE[12] = '{8, 11, 9, 12, 13, 2, 7, 4, 1, 3, 8, 63};

    logic        clk = 1'b0;
    logic        reset;
    logic        retire_en;
    logic [31:0] era_entry, ex_entry, tlbr_entry;
    logic        rf_we, flush, ex_valid, tlb_we, tlb_re;
    logic [4:0]  rf_waddr, fwd_dest;
    logic [31:0] rf_wdata, fwd_value, flush_target, ex_pc;
    logic [5:0]  ex_ecode;
    logic [8:0]  ex_esubcode;
`ifdef WB_COMMIT_PERF_CNT_EN
    logic [31:0] perf_retire_cnt, perf_flush_cnt;
`endif

    int checks = 0;
    int failures = 0;

    wb_commit_if #(.TLBNUM(16)) bus ();

    wb_commit #(.DEPTH(DEPTH), .TLBNUM(16)) dut (
        .clk(clk), .reset(reset), .up(bus), .retire_en(retire_en),
        .era_entry(era_entry), .ex_entry(ex_entry), .tlbr_entry(tlbr_entry),
        .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
        .fwd_dest(fwd_dest), .fwd_value(fwd_value),
        .flush(flush), .flush_target(flush_target),
        .ex_valid(ex_valid), .ex_ecode(ex_ecode),
        .ex_esubcode(ex_esubcode), .ex_pc(ex_pc),
        .tlb_we(tlb_we), .tlb_re(tlb_re)
`ifdef WB_COMMIT_PERF_CNT_EN
        , .perf_retire_cnt(perf_retire_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] res;
        logic        we;
        logic [4:0]  dest;
        logic [15:0] cause;
        logic        ertn;
        logic        refetch;
        logic [4:0]  op;
    } ent_t;

    typedef struct packed {
        logic        allow, ret, fl, rfwe, exv, twe, tre;
        logic [4:0]  waddr, fd;
        logic [31:0] wdata, expc, tgt, fv;
        logic [5:0]  ec;
        logic [8:0]  es;
    } exp_t;

    ent_t mq[$];
    logic [31:0] m_rc = 0;
    logic [31:0] m_fc = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    function automatic exp_t eval();
        exp_t e;
        ent_t h;
        logic hx;
        e = '0;
        for (int i = 0; i < mq.size(); i++)
            if (mq[i].we) begin
                e.fd = mq[i].dest;
                e.fv = mq[i].res;
            end
        if (!reset && mq.size() > 0 && retire_en) begin
            h = mq[0];
            e.ret = 1'b1;
            hx = |h.cause;
            for (int k = 11; k >= 0; k--)
                if (h.cause[PB[k]]) begin
                    e.ec = 6'(PE[k]);
                    e.es = (PB[k] == 13) ? 9'd1 : 9'd0;
                end
            e.fl = hx | h.ertn | h.refetch;
            if (hx) begin
                e.exv  = 1'b1;
                e.expc = h.pc;
            end else begin
                e.ec    = '0;
                e.rfwe  = h.we;
                e.waddr = h.dest;
                e.wdata = h.res;
                e.twe   = h.op[2] | h.op[1];
                e.tre   = h.op[3];
            end
            if (h.ertn)     e.tgt = era_entry;
            else if (hx)    e.tgt = (e.ec == 6'h3F) ? tlbr_entry : ex_entry;
            else            e.tgt = h.pc + 32'd4;
        end
        e.allow = !e.fl && (mq.size() < DEPTH || e.ret);
        return e;
    endfunction

    always @(posedge clk or posedge reset) begin
        exp_t e;
        ent_t n;
        if (reset) begin
            mq.delete();
            m_rc = 0;
            m_fc = 0;
        end else begin
            e = eval();
            if (e.ret) m_rc = m_rc + 1;
            if (e.fl)  m_fc = m_fc + 1;
            if (e.fl) mq.delete();
            else begin
                if (e.ret) void'(mq.pop_front());
                if (bus.ms_to_ws_valid && e.allow) begin
                    n = {bus.in_pc, bus.in_result, bus.in_gr_we, bus.in_dest,
                         bus.in_ex_cause, bus.in_ertn, bus.in_refetch,
                         bus.in_tlbop};
                    mq.push_back(n);
                end
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        e = eval();
        chk("allowin", bus.ws_allowin, e.allow);
        chk("rf_we", rf_we, e.rfwe);
        chk("ex_valid", ex_valid, e.exv);
        chk("flush", flush, e.fl);
        chk("tlb_we", tlb_we, e.twe);
        chk("tlb_re", tlb_re, e.tre);
        chk("fwd_dest", fwd_dest, e.fd);
        if (e.fd != 0 || e.fv != 0) chk("fwd_value", fwd_value, e.fv);
        if (e.rfwe) begin
            chk("rf_waddr", rf_waddr, e.waddr);
            chk("rf_wdata", rf_wdata, e.wdata);
        end
        if (e.exv) begin
            chk("ecode", ex_ecode, e.ec);
            chk("esub", ex_esubcode, e.es);
            chk("ex_pc", ex_pc, e.expc);
        end
        if (e.fl) chk("target", flush_target, e.tgt);
`ifdef WB_COMMIT_PERF_CNT_EN
        chk("perf_ret", perf_retire_cnt, m_rc);
        chk("perf_fl", perf_flush_cnt, m_fc);
`endif
    end

    task automatic push(input logic [31:0] pc, input logic [31:0] res,
                        input logic we, input logic [4:0] d,
                        input logic [15:0] c, input logic er,
                        input logic rf, input logic [4:0] op);
        bus.ms_to_ws_valid = 1'b1;
        bus.in_pc       = pc;
        bus.in_result   = res;
        bus.in_gr_we    = we;
        bus.in_dest     = d;
        bus.in_ex_cause = c;
        bus.in_ertn     = er;
        bus.in_refetch  = rf;
        bus.in_tlbop    = op;
    endtask

    task automatic idle();
        bus.ms_to_ws_valid = 1'b0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        #3;
    endtask

    initial begin
        reset = 1'b0;
        retire_en = 1'b0;
        era_entry = 32'h0;
        ex_entry = 32'h1C00_8000;
        tlbr_entry = 32'h1C00_F000;
        bus.tlb_index = 4'h3;
        push(0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        #1 reset = 1'b1;
        #2;
        chk("rst_allowin", bus.ws_allowin, 1);
        chk("rst_rf_we", rf_we, 0);
        chk("rst_flush", flush, 0);
        chk("rst_target", flush_target, 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // fill to DEPTH, then retire and enqueue in the same cycle
        push(32'h1000, 32'hDEADBEEF, 1, 5, 0, 0, 0, 0);
        cyc();
        push(32'h1004, 32'h11, 1, 6, 0, 0, 0, 0);
        cyc();
        idle();
        look();
        chk("full_allowin", bus.ws_allowin, 0);
        chk("fwd_young_d", fwd_dest, 6);
        chk("fwd_young_v", fwd_value, 32'h11);
        retire_en = 1'b1;
        push(32'h1008, 32'h22, 0, 7, 0, 0, 0, 0);
        look();
        chk("ret_allowin", bus.ws_allowin, 1);
        chk("ret_rf_we", rf_we, 1);
        chk("ret_waddr", rf_waddr, 5);
        chk("ret_wdata", rf_wdata, 32'hDEADBEEF);
        chk("ret_flush", flush, 0);
        cyc();
        idle();
        retire_en = 1'b0;
        look();
        chk("still_full", bus.ws_allowin, 0);
        cyc();
        retire_en = 1'b1;
        look();
        chk("ret2_waddr", rf_waddr, 6);
        cyc();
        cyc();
        chk("empty_rf_we", rf_we, 0);

        // exception flush drops the younger entry
        retire_en = 1'b0;
        push(32'h1C00_0010, 0, 0, 0, 16'h0006, 0, 0, 0);
        cyc();
        push(32'h2000, 32'h5, 1, 3, 0, 0, 0, 0);
        cyc();
        idle();
        retire_en = 1'b1;
        look();
        chk("exc_valid", ex_valid, 1);
        chk("exc_ecode", ex_ecode, 6'h08);
        chk("exc_esub", ex_esubcode, 0);
        chk("exc_pc", ex_pc, 32'h1C00_0010);
        chk("exc_target", flush_target, 32'h1C00_8000);
        chk("exc_allowin", bus.ws_allowin, 0);
        cyc();
        look();
        chk("post_fl_fwd", fwd_dest, 0);
        chk("post_fl_rfwe", rf_we, 0);
        cyc();

        // TLB refill exception suppresses tlbwr
        retire_en = 1'b0;
        push(32'h3000, 0, 0, 0, 16'h0800, 0, 0, 5'b00100);
        cyc();
        idle();
        retire_en = 1'b1;
        look();
        chk("tlbr_ecode", ex_ecode, 6'h3F);
        chk("tlbr_target", flush_target, 32'h1C00_F000);
        chk("tlbr_tlb_we", tlb_we, 0);
        cyc();

        // refetch wraps pc+4 and drops the concurrent push
        retire_en = 1'b0;
        push(32'hFFFF_FFFC, 32'h9, 1, 7, 0, 0, 1, 0);
        cyc();
        retire_en = 1'b1;
        push(32'h4000, 32'hAB, 1, 8, 0, 0, 0, 0);
        look();
        chk("rfch_target", flush_target, 32'h0);
        chk("rfch_allowin", bus.ws_allowin, 0);
        chk("rfch_rf_we", rf_we, 1);
        cyc();
        idle();
        look();
        chk("rfch_drop", fwd_dest, 0);
        cyc();

        // ertn outranks the exception for the target
        retire_en = 1'b0;
        era_entry = 32'h1C00_1234;
        push(32'h5000, 0, 0, 0, 16'h0008, 1, 0, 0);
        cyc();
        idle();
        retire_en = 1'b1;
        look();
        chk("ertn_target", flush_target, 32'h1C00_1234);
        chk("ertn_ecode", ex_ecode, 6'h09);
        cyc();

        // tlbrd then tlbfill
        retire_en = 1'b0;
        push(32'h7000, 0, 0, 0, 0, 0, 0, 5'b01000);
        cyc();
        push(32'h7004, 0, 0, 0, 0, 0, 0, 5'b00010);
        cyc();
        idle();
        retire_en = 1'b1;
        look();
        chk("tlbrd_re", tlb_re, 1);
        cyc();
        look();
        chk("tlbfill_we", tlb_we, 1);
        cyc();

        // every single cause bit, plus all bits at once
        for (int b = 0; b <= 16; b++) begin
            retire_en = 1'b0;
            push(32'(32'h8000 + 4 * b), 0, 1, 1, (b == 16) ? 16'hFFFF : 16'(1 << b),
                 0, 0, 0);
            cyc();
            idle();
            retire_en = 1'b1;
            look();
            if (b == 0)  chk("c0_ecode", ex_ecode, 0);
            if (b == 0)  chk("c0_target", flush_target, 32'h1C00_8000);
            if (b == 13) chk("c13_esub", ex_esubcode, 1);
            if (b == 16) chk("call_ecode", ex_ecode, 6'h08);
            cyc();
        end

        // streaming mix, exercises pointer wrap
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(3, 0) != 0)
                push($urandom & 32'hFFFF_FFFC, $urandom, 1'($urandom_range(1, 0)),
                     5'($urandom_range(31, 0)),
                     ($urandom_range(7, 0) == 0) ? 16'(1 << $urandom_range(15, 0)) : 16'h0,
                     ($urandom_range(15, 0) == 0), 1'b0,
                     5'(1 << $urandom_range(4, 0)));
            else
                idle();
            retire_en = 1'($urandom_range(1, 0));
            cyc();
        end

        // reset mid-queue, no clock edge
        idle();
        retire_en = 1'b1;
        cyc();
        cyc();
        cyc();
        retire_en = 1'b0;
        push(32'hA000, 32'h1, 1, 9, 0, 0, 0, 0);
        cyc();
        push(32'hA004, 32'h2, 1, 10, 0, 0, 0, 0);
        cyc();
        idle();
        #2 reset = 1'b1;
        #1;
        chk("mrst_allowin", bus.ws_allowin, 1);
        chk("mrst_rf_we", rf_we, 0);
        chk("mrst_fwd", fwd_dest, 0);
`ifdef WB_COMMIT_PERF_CNT_EN
        chk("mrst_perf_r", perf_retire_cnt, 0);
        chk("mrst_perf_f", perf_flush_cnt, 0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        retire_en = 1'b1;
        look();
        chk("mrst_noret", rf_we, 0);
        chk("mrst_noexc", ex_valid, 0);
        cyc();
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
